// File: rtl/odd_sequence_checker.sv
// Integrity checker and index decoder for the 4-bit odd up/down counter stream.
// Optional build macro STICKY_ERR_EN adds clr_err / err_sticky.
module odd_sequence_checker #(
    parameter int unsigned LOCK_LEN  = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [3:0]           count_in,
    input  logic                 y_in,
`ifdef STICKY_ERR_EN
    input  logic                 clr_err,
    output logic                 err_sticky,
`endif
    output logic [2:0]           index,
    output logic [3:0]           last_count,
    output logic                 locked,
    output logic                 error,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

    state_e               state_q, state_d;
    logic [3:0]           last_count_q, last_count_d;
    logic [3:0]           good_cnt_q, good_cnt_d;
    logic                 locked_q, locked_d;
    logic                 error_q, error_d;
    logic                 wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [3:0] successor;
    logic [3:0] good_inc;
    logic       is_odd, is_legal, is_wrap, lock_hit, err_inc;

    // Successor is computed in 4 bits so 15+2 -> 1 and 1-2 -> 15 fall out naturally.
    assign successor = y_in ? last_count_q + 4'd2 : last_count_q - 4'd2;
    assign is_odd    = count_in[0];
    assign is_legal  = (count_in == successor);
    assign is_wrap   = is_legal && (y_in ? (last_count_q == 4'd15) : (last_count_q == 4'd1));
    assign good_inc  = good_cnt_q + 4'd1;
    assign lock_hit  = (good_inc == 4'(LOCK_LEN));

    // NOTE: async reset sits in the sensitivity list; all state uses <= so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_count_q <= 4'b0001;
            good_cnt_q   <= 4'd0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            wrap_q       <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_count_q <= last_count_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            wrap_q       <= wrap_d;
            err_count_q  <= err_count_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (sample_valid) begin
            if (!is_odd) begin
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE:    state_d = ACQUIRE;
                    ACQUIRE: if (is_legal && lock_hit) state_d = LOCKED;
                    LOCKED:  if (!is_legal) state_d = ACQUIRE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        last_count_d = last_count_q;
        good_cnt_d   = good_cnt_q;
        locked_d     = locked_q;
        wrap_d       = 1'b0;
        err_inc      = 1'b0;
        if (sample_valid) begin
            if (!is_odd) begin
                err_inc    = 1'b1;
                locked_d   = 1'b0;
                good_cnt_d = 4'd0;
            end else begin
                last_count_d = count_in;
                unique case (state_q)
                    IDLE: good_cnt_d = 4'd0;
                    ACQUIRE: begin
                        if (is_legal) begin
                            good_cnt_d = good_inc;
                            wrap_d     = is_wrap;
                            if (lock_hit) locked_d = 1'b1;
                        end else begin
                            good_cnt_d = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (is_legal) begin
                            wrap_d = is_wrap;
                        end else begin
                            err_inc    = 1'b1;
                            locked_d   = 1'b0;
                            good_cnt_d = 4'd0;
                        end
                    end
                    default: good_cnt_d = 4'd0;
                endcase
            end
        end
        error_d     = err_inc;
        err_count_d = err_count_q;
        if (err_inc && (err_count_q != '1)) err_count_d = err_count_q + ERR_CNT_W'(1);
`ifdef STICKY_ERR_EN
        // A clear coinciding with an error leaves that error counted.
        if (clr_err) err_count_d = err_inc ? ERR_CNT_W'(1) : '0;
`endif
    end

`ifdef STICKY_ERR_EN
    logic sticky_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sticky_q <= 1'b0;
        else        sticky_q <= err_inc | (sticky_q & ~clr_err);
    end
    assign err_sticky = sticky_q;
`endif

    assign index      = last_count_q[3:1];
    assign last_count = last_count_q;
    assign locked     = locked_q;
    assign error      = error_q;
    assign wrap       = wrap_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_odd_sequence_checker.sv
// Directed self-checking bench for odd_sequence_checker (LOCK_LEN=2, ERR_CNT_W=2).
module tb_odd_sequence_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_valid = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic       y_in = 1'b0;
    logic [2:0] index;
    logic [3:0] last_count;
    logic       locked, error, wrap;
    logic [1:0] err_count;

    int checks = 0;
    int errors = 0;

    // Observed bundle: {index, last_count, locked, error, wrap, err_count}
    logic [11:0] obs;
    assign obs = {index, last_count, locked, error, wrap, err_count};

    always #5 clk = ~clk;

    odd_sequence_checker #(.LOCK_LEN(2), .ERR_CNT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .count_in     (count_in),
        .y_in         (y_in),
        .index        (index),
        .last_count   (last_count),
        .locked       (locked),
        .error        (error),
        .wrap         (wrap),
        .err_count    (err_count)
    );

    task automatic send(input logic [3:0] c, input logic y);
        @(negedge clk);
        count_in     = c;
        y_in         = y;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        count_in     = 4'd6;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cmp(input string name, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got idx=%0d last=%0d lock=%b err=%b wrap=%b cnt=%0d, want idx=%0d last=%0d lock=%b err=%b wrap=%b cnt=%0d",
                     name, obs[11:9], obs[8:5], obs[4], obs[3], obs[2], obs[1:0],
                     exp[11:9], exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        cmp("reset", {3'd0, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0});
    endtask

    task automatic test_lock_up();
        do_reset();
        send(4'd1, 1'b1); cmp("lock_s1", {3'd0, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0});
        send(4'd3, 1'b1); cmp("lock_s3", {3'd1, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0});
        send(4'd5, 1'b1); cmp("lock_s5", {3'd2, 4'd5, 1'b1, 1'b0, 1'b0, 2'd0});
        send(4'd7, 1'b1); cmp("lock_s7", {3'd3, 4'd7, 1'b1, 1'b0, 1'b0, 2'd0});
    endtask

    task automatic test_up_wrap();
        do_reset();
        send(4'd9, 1'b1);
        send(4'd11, 1'b1);
        send(4'd13, 1'b1); cmp("upw_13", {3'd6, 4'd13, 1'b1, 1'b0, 1'b0, 2'd0});
        send(4'd15, 1'b1); cmp("upw_15", {3'd7, 4'd15, 1'b1, 1'b0, 1'b0, 2'd0});
        send(4'd1, 1'b1);  cmp("upw_1",  {3'd0, 4'd1, 1'b1, 1'b0, 1'b1, 2'd0});
        idle_cycle();      cmp("upw_idle", {3'd0, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0});
    endtask

    task automatic test_down_wrap();
        do_reset();
        send(4'd7, 1'b0);
        send(4'd5, 1'b0);
        send(4'd3, 1'b0);  cmp("dnw_3",  {3'd1, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0});
        send(4'd1, 1'b0);  cmp("dnw_1",  {3'd0, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0});
        send(4'd15, 1'b0); cmp("dnw_15", {3'd7, 4'd15, 1'b1, 1'b0, 1'b1, 2'd0});
        send(4'd1, 1'b1);  cmp("dnw_up1", {3'd0, 4'd1, 1'b1, 1'b0, 1'b1, 2'd0});
        send(4'd3, 1'b1);  cmp("dnw_up3", {3'd1, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0});
    endtask

    task automatic test_mismatch();
        do_reset();
        send(4'd3, 1'b1);
        send(4'd5, 1'b1);
        send(4'd7, 1'b1);  cmp("mis_7",  {3'd3, 4'd7, 1'b1, 1'b0, 1'b0, 2'd0});
        send(4'd11, 1'b1); cmp("mis_11", {3'd5, 4'd11, 1'b0, 1'b1, 1'b0, 2'd1});
        send(4'd13, 1'b1); cmp("mis_13", {3'd6, 4'd13, 1'b0, 1'b0, 1'b0, 2'd1});
        send(4'd15, 1'b1); cmp("mis_15", {3'd7, 4'd15, 1'b1, 1'b0, 1'b0, 2'd1});
    endtask

    task automatic test_acquire_resync();
        do_reset();
        // First sample after IDLE is a capture: 1->15 down must not count as a wrap.
        send(4'd15, 1'b0); cmp("acq_cap", {3'd7, 4'd15, 1'b0, 1'b0, 1'b0, 2'd0});
        send(4'd5, 1'b1);  cmp("acq_bad", {3'd2, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0});
        send(4'd9, 1'b1);  cmp("acq_bad2", {3'd4, 4'd9, 1'b0, 1'b0, 1'b0, 2'd0});
        send(4'd11, 1'b1); cmp("acq_g1",  {3'd5, 4'd11, 1'b0, 1'b0, 1'b0, 2'd0});
        send(4'd13, 1'b1); cmp("acq_g2",  {3'd6, 4'd13, 1'b1, 1'b0, 1'b0, 2'd0});
    endtask

    task automatic test_even();
        do_reset();
        send(4'd1, 1'b1);
        send(4'd3, 1'b1);
        send(4'd5, 1'b1); cmp("even_lock", {3'd2, 4'd5, 1'b1, 1'b0, 1'b0, 2'd0});
        send(4'd6, 1'b1); cmp("even_6",    {3'd2, 4'd5, 1'b0, 1'b1, 1'b0, 2'd1});
        send(4'd9, 1'b1); cmp("even_9",    {3'd4, 4'd9, 1'b0, 1'b0, 1'b0, 2'd1});
        send(4'd11, 1'b1); cmp("even_11",  {3'd5, 4'd11, 1'b0, 1'b0, 1'b0, 2'd1});
    endtask

    task automatic test_saturation();
        do_reset();
        send(4'd0, 1'b1);  cmp("sat_1", {3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'd1});
        send(4'd2, 1'b0);  cmp("sat_2", {3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'd2});
        send(4'd4, 1'b1);  cmp("sat_3", {3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'd3});
        send(4'd8, 1'b1);  cmp("sat_4", {3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'd3});
        send(4'd14, 1'b0); cmp("sat_5", {3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'd3});
        idle_cycle();      cmp("sat_idle", {3'd0, 4'd1, 1'b0, 1'b0, 1'b0, 2'd3});
    endtask

    task automatic test_async_reset();
        do_reset();
        send(4'd10, 1'b1);
        send(4'd1, 1'b1);
        send(4'd3, 1'b1);
        send(4'd5, 1'b1); cmp("arst_pre", {3'd2, 4'd5, 1'b1, 1'b0, 1'b0, 2'd1});
        // Assert reset mid-cycle, well clear of either clock edge.
        #2;
        reset = 1'b0;
        #1;
        cmp("arst_mid", {3'd0, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0});
        @(negedge clk);
        reset = 1'b1;
        send(4'd9, 1'b1);  cmp("arst_cap", {3'd4, 4'd9, 1'b0, 1'b0, 1'b0, 2'd0});
        send(4'd11, 1'b1); cmp("arst_g1",  {3'd5, 4'd11, 1'b0, 1'b0, 1'b0, 2'd0});
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_up_wrap();
        test_down_wrap();
        test_mismatch();
        test_acquire_resync();
        test_even();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
